// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: leader, 32 data bits LSB first, stop mark, then a gap up to the frame period.
// Define IR_TX_CARRIER_EN to gate marks with the ~38 kHz carrier; undefined, ir_tx is the bare envelope.
module nec_ir_tx #(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned FRAME_UNITS  = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        repeat_code,
  input  logic [7:0]  addr,
  input  logic [7:0]  cmd,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_tx,
  output logic [31:0] data_word
);

  localparam int unsigned UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [7:0] FRAME_MAX  = 8'(FRAME_UNITS);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_UNITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  state_t state, next_state;

  logic [UNIT_W-1:0] unit_cnt;
  logic [7:0]        frame_cnt;
  logic [3:0]        seg_cnt;
  logic [3:0]        seg_last;
  logic [4:0]        bit_idx;
  logic [31:0]       shreg;
  logic              rep;
  logic              accept;
  logic              tick;
  logic              seg_end;

  assign accept  = (state == IDLE) && start;
  assign tick    = (state != IDLE) && (unit_cnt == UNIT_LAST);
  assign seg_end = tick && (seg_cnt == seg_last);

  // Segment length in units, minus one, for the current state.
  always_comb begin
    seg_last = 4'd0;
    case (state)
      LEAD_MARK:  seg_last = 4'd15;
      LEAD_SPACE: seg_last = rep ? 4'd3 : 4'd7;
      BIT_SPACE:  seg_last = shreg[0] ? 4'd2 : 4'd0;
      default:    seg_last = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    ir_env     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LEAD_MARK;
      end
      LEAD_MARK: begin
        ir_env = 1'b1;
        if (seg_end) next_state = LEAD_SPACE;
      end
      LEAD_SPACE: begin
        if (seg_end) next_state = rep ? STOP_MARK : BIT_MARK;
      end
      BIT_MARK: begin
        ir_env = 1'b1;
        if (seg_end) next_state = BIT_SPACE;
      end
      BIT_SPACE: begin
        if (seg_end) next_state = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: begin
        ir_env = 1'b1;
        if (seg_end) next_state = GAP;
      end
      GAP: begin
        // done lands in the last cycle of the final unit, so the frame period is exact.
        if (tick && (frame_cnt >= FRAME_LAST)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_cnt  <= '0;
      frame_cnt <= '0;
      seg_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rep       <= 1'b0;
      data_word <= '0;
    end else if (accept) begin
      unit_cnt  <= '0;
      frame_cnt <= '0;
      seg_cnt   <= '0;
      bit_idx   <= '0;
      rep       <= repeat_code;
      if (!repeat_code) begin
        shreg     <= {~cmd, cmd, ~addr, addr};
        data_word <= {~cmd, cmd, ~addr, addr};
      end
    end else if (state != IDLE) begin
      if (tick) begin
        unit_cnt <= '0;
        if (frame_cnt < FRAME_MAX) frame_cnt <= frame_cnt + 8'd1;
      end else begin
        unit_cnt <= unit_cnt + UNIT_W'(1);
      end
      if (next_state != state) seg_cnt <= '0;
      else if (tick)           seg_cnt <= seg_cnt + 4'd1;
      if ((state == BIT_SPACE) && seg_end) begin
        shreg   <= {1'b0, shreg[31:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

`ifdef IR_TX_CARRIER_EN
  localparam int unsigned CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_HALF - 1);

  logic [CAR_W-1:0] car_cnt;
  logic             car_lvl;
  logic             mark_next;

  assign mark_next = (next_state == LEAD_MARK) || (next_state == BIT_MARK) ||
                     (next_state == STOP_MARK);

  // Every mark follows a space, so restarting the phase on entry gives a high first half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_cnt <= '0;
      car_lvl <= 1'b0;
    end else if (mark_next && !ir_env) begin
      car_cnt <= '0;
      car_lvl <= 1'b1;
    end else if (car_cnt == CAR_LAST) begin
      car_cnt <= '0;
      car_lvl <= ~car_lvl;
    end else begin
      car_cnt <= car_cnt + CAR_W'(1);
    end
  end

  assign ir_tx = ir_env & car_lvl;
`else
  assign ir_tx = ir_env;
`endif

endmodule
